// File: rtl/lb_pkg.sv
// Shared types and defaults for the 3-row linebuffer sequencer.
package lb_pkg;
    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} lb_state_e;

    localparam int LB_BIT_DEPTH = 8;
    localparam int LB_COLS      = 28;
    localparam int LB_ROWS      = 28;

    // counter width for a range of n values, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/linebuffer_ctrl_addr_gen.sv
// Read-side address generator: tracks the next (strip, column) to fetch and the
// three row addresses presented to feature-map memory.
module lb_addr_gen import lb_pkg::*; #(
    parameter int COLS   = LB_COLS,
    parameter int ROWS   = LB_ROWS,
    parameter int ADDR_W = $clog2(LB_ROWS * LB_COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr_r1,
    output logic [ADDR_W-1:0] addr_r2,
    output logic [ADDR_W-1:0] addr_r3,
    output logic              in_valid
);
    localparam int CW = cnt_w(COLS);
    localparam int SW = cnt_w(ROWS);

    logic [CW-1:0] in_col;
    logic [SW-1:0] in_strip;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            in_col   <= '0;
            in_strip <= '0;
            addr_r1  <= '0;
            addr_r2  <= '0;
            addr_r3  <= '0;
        end else if (init) begin
            in_col   <= '0;
            in_strip <= '0;
            addr_r1  <= '0;
            addr_r2  <= ADDR_W'(COLS);
            addr_r3  <= ADDR_W'(2 * COLS);
        end else if (adv) begin
            // rows are contiguous, so stepping past the last column lands on the next row base
            addr_r1 <= addr_r1 + ADDR_W'(1);
            addr_r2 <= addr_r2 + ADDR_W'(1);
            addr_r3 <= addr_r3 + ADDR_W'(1);
            if (in_col == CW'(COLS - 1)) begin
                in_col   <= '0;
                in_strip <= in_strip + SW'(1);
            end else begin
                in_col <= in_col + CW'(1);
            end
        end
    end

    assign in_valid = (in_strip <= SW'(ROWS - 3));
endmodule

// File: rtl/linebuffer_ctrl.sv
// Linebuffer sequencer: fills strip 0, then streams each strip while fetching the next.
// Optional STALL_CNT_EN adds a saturating stall_cycles counter.
//
//  state  | meaning
//  IDLE   | waiting for start
//  FILL   | loading the first strip into the linebuffer
//  STREAM | handing tail columns to conv while fetching the next strip
//  DONE   | one-cycle done pulse
module linebuffer_ctrl import lb_pkg::*; #(
    parameter int COLS   = LB_COLS,
    parameter int ROWS   = LB_ROWS,
    parameter int ADDR_W = $clog2(ROWS * COLS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr_r1,
    output logic [ADDR_W-1:0]        mem_addr_r2,
    output logic [ADDR_W-1:0]        mem_addr_r3,
    output logic                     lb_shift,
    output logic                     lb_zero_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [cnt_w(COLS)-1:0]   out_col,
    output logic [cnt_w(ROWS)-1:0]   out_strip,
    output logic                     out_last
`ifdef STALL_CNT_EN
   ,output logic [15:0]              stall_cycles
`endif
);
    localparam int CW = cnt_w(COLS);
    localparam int SW = cnt_w(ROWS);

    lb_state_e     state, state_nx;
    logic          pending;
    logic [CW-1:0] col_q;
    logic [SW-1:0] strip_q;
    logic          in_valid, addr_init, addr_clr;
    logic          last_col, last_strip;

    assign last_col   = (col_q == CW'(COLS - 1));
    assign last_strip = (strip_q == SW'(ROWS - 3));

    always_comb begin
        state_nx   = state;
        mem_rd_en  = 1'b0;
        lb_shift   = 1'b0;
        lb_zero_in = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        addr_init  = 1'b0;
        addr_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_init = 1'b1;
                    state_nx  = FILL;
                end
            end
            FILL: begin
                // col_q counts fill shifts; it wraps back to 0 as streaming begins
                lb_shift  = pending;
                mem_rd_en = in_valid;
                if (pending && last_col) state_nx = STREAM;
            end
            STREAM: begin
                out_valid  = pending | last_strip;
                lb_shift   = out_valid & out_ready;
                mem_rd_en  = lb_shift & in_valid;
                lb_zero_in = last_strip;
                if (lb_shift && last_col && last_strip) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                addr_clr = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
            col_q   <= '0;
            strip_q <= '0;
        end else begin
            state <= state_nx;
            if (mem_rd_en)     pending <= 1'b1;
            else if (lb_shift) pending <= 1'b0;
            if (lb_shift) col_q <= last_col ? '0 : col_q + CW'(1);
            if (state == STREAM && lb_shift && last_col && !last_strip)
                strip_q <= strip_q + SW'(1);
            else if (state == DONE)
                strip_q <= '0;
        end
    end

    lb_addr_gen #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (addr_init),
        .clr      (addr_clr),
        .adv      (mem_rd_en),
        .addr_r1  (mem_addr_r1),
        .addr_r2  (mem_addr_r2),
        .addr_r3  (mem_addr_r3),
        .in_valid (in_valid)
    );

    assign busy      = (state != IDLE);
    assign out_col   = col_q;
    assign out_strip = strip_q;
    assign out_last  = (state == STREAM) & last_strip & last_col;

`ifdef STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && start))
            stall_q <= '0;
        else if (out_valid && !out_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cycles = stall_q;
`endif
endmodule
